// File: rtl/riscv_bus_pkg.sv
// riscv_bus_pkg: shared types and bus widths for the instruction/data bus arbiter
package riscv_bus_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic {OWN_INSTR, OWN_DATA} owner_e;
    typedef enum logic {FREE, HOLD} hold_state_e;
endpackage

// File: rtl/riscv_bus_if.sv
// riscv_bus_if: request/grant/response bus bundle; the master issues requests, the slave grants and responds
interface riscv_bus_if;
    logic                              req;
    logic                              we;
    logic [riscv_bus_pkg::BE_W-1:0]    be;
    logic [riscv_bus_pkg::ADDR_W-1:0]  addr;
    logic [riscv_bus_pkg::DATA_W-1:0]  wdata;
    logic                              gnt;
    logic                              rvalid;
    logic [riscv_bus_pkg::DATA_W-1:0]  rdata;

    modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/riscv_bus_owner_fifo.sv
// riscv_bus_owner_fifo: in-order record of which requester owns each outstanding transaction
module riscv_bus_owner_fifo #(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             din,
    input  logic             pop,
    output logic             head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    logic [DEPTH-1:0] slots;
    logic [PTR_W-1:0] rdPtr, wrPtr;
    logic             doPush, doPop;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return p == PTR_W'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign full   = count == CNT_W'(DEPTH);
    assign empty  = count == '0;
    assign doPush = push & ~full;
    assign doPop  = pop & ~empty;
    assign head   = slots[rdPtr];

    // Pointer and occupancy tracking; a simultaneous push and pop leaves count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= nextPtr(wrPtr);
            if (doPop) rdPtr <= nextPtr(rdPtr);
            count <= count + CNT_W'(doPush) - CNT_W'(doPop);
        end
    end

    // Payload storage needs no reset: only slots behind a valid count are ever read
    always_ff @(posedge clk) begin
        if (doPush) slots[wrPtr] <= din;
    end
endmodule

// File: rtl/riscv_bus_arbiter.sv
// riscv_bus_arbiter: merges fetch and data ports onto one memory port with data priority and anti-starvation
module riscv_bus_arbiter
    import riscv_bus_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    riscv_bus_if.slave   instrBus,
    riscv_bus_if.slave   dataBus,
    riscv_bus_if.master  memBus,
    output logic         o_resp_err
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

    hold_state_e      holdQ;
    owner_e           holdOwnerQ, owner, headOwner;
    logic [ST_W-1:0]  starveQ;
    logic [CNT_W-1:0] outstanding;
    logic             ownerValid, isData, grant, full, empty, headBit, respValid;

    // Owner choice: a held owner wins outright, otherwise data unless the fetch side is being starved
    always_comb begin
        ownerValid = holdQ == HOLD || instrBus.req || dataBus.req;
        owner = holdQ == HOLD ? holdOwnerQ :
                (dataBus.req && (starveQ < ST_W'(STARVE_LIMIT) || !instrBus.req)) ? OWN_DATA : OWN_INSTR;
    end

    assign isData        = owner == OWN_DATA;
    assign memBus.req    = rst_n && ownerValid && !full;
    assign memBus.we     = isData & dataBus.we;
    assign memBus.be     = isData ? dataBus.be : 4'hF;
    assign memBus.addr   = isData ? dataBus.addr : instrBus.addr;
    assign memBus.wdata  = isData ? dataBus.wdata : '0;
    assign grant         = memBus.req & memBus.gnt;
    assign dataBus.gnt   = grant & isData;
    assign instrBus.gnt  = grant & ~isData;

    assign headOwner       = owner_e'(headBit);
    assign respValid       = memBus.rvalid & ~empty;
    assign dataBus.rvalid  = respValid & (headOwner == OWN_DATA);
    assign instrBus.rvalid = respValid & (headOwner == OWN_INSTR);
    assign dataBus.rdata   = memBus.rdata;
    assign instrBus.rdata  = memBus.rdata;

    riscv_bus_owner_fifo #(.DEPTH(MAX_OUTSTANDING)) ownerFifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (grant),
        .din   (owner),
        .pop   (memBus.rvalid),
        .head  (headBit),
        .count (outstanding),
        .full  (full),
        .empty (empty)
    );

    // Hold FSM: a stalled request keeps its owner until memory accepts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            holdQ      <= FREE;
            holdOwnerQ <= OWN_INSTR;
        end else if (holdQ == FREE && memBus.req && !memBus.gnt) begin
            holdQ      <= HOLD;
            holdOwnerQ <= owner;
        end else if (holdQ == HOLD && grant) begin
            holdQ <= FREE;
        end
    end

    // Counts data grants taken while a fetch waits; saturates so the fetch is forced next
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) starveQ <= '0;
        else if (grant) starveQ <= (isData && instrBus.req) ?
                                   (starveQ == ST_W'(STARVE_LIMIT) ? starveQ : starveQ + 1'b1) : '0;
    end

    // Sticky flag for a response arriving with nothing outstanding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) o_resp_err <= 1'b0;
        else if (memBus.rvalid && outstanding == '0) o_resp_err <= 1'b1;
    end
endmodule

// File: tb/tb_riscv_bus_arbiter.sv
// tb_riscv_bus_arbiter: directed vectors with hand-computed expectations for the bus arbiter
module tb_riscv_bus_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic respErr;
    int   checks = 0;
    int   failures = 0;

    riscv_bus_if instrBus ();
    riscv_bus_if dataBus ();
    riscv_bus_if memBus ();

    riscv_bus_arbiter #(.MAX_OUTSTANDING(2), .STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instrBus   (instrBus),
        .dataBus    (dataBus),
        .memBus     (memBus),
        .o_resp_err (respErr)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs;
        instrBus.req = 0; instrBus.we = 0; instrBus.be = 4'h0; instrBus.addr = 0; instrBus.wdata = 0;
        dataBus.req = 0; dataBus.we = 0; dataBus.be = 4'h0; dataBus.addr = 0; dataBus.wdata = 0;
        memBus.gnt = 0; memBus.rvalid = 0; memBus.rdata = 0;
    endtask

    task automatic doReset;
        rst_n = 0;
        clearInputs();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1;
    endtask

    initial begin
        logic [9:0] seq;
        clearInputs();
        instrBus.req = 1; dataBus.req = 1; memBus.gnt = 1;
        #3;
        checkEq("rstMemReq", memBus.req, 0);
        checkEq("rstInstrGnt", instrBus.gnt, 0);
        checkEq("rstDataGnt", dataBus.gnt, 0);
        checkEq("rstErr", respErr, 0);

        // Starvation pattern: D,D,D,D,I,D,D,D,D,I with responses one cycle after each grant
        doReset();
        seq = 10'b0111101111;
        instrBus.req = 1; instrBus.addr = 32'h40;
        dataBus.req = 1; dataBus.addr = 32'h80; dataBus.be = 4'h3;
        memBus.gnt = 1;
        for (int k = 0; k < 10; k++) begin
            memBus.rvalid = k > 0;
            memBus.rdata = 32'h1000 + k;
            #4;
            checkEq("t1DataGnt", dataBus.gnt, seq[k]);
            checkEq("t1InstrGnt", instrBus.gnt, !seq[k]);
            checkEq("t1Addr", memBus.addr, seq[k] ? 32'h80 : 32'h40);
            checkEq("t1Be", memBus.be, seq[k] ? 4'h3 : 4'hF);
            if (k > 0) begin
                checkEq("t1DataRvalid", dataBus.rvalid, seq[k-1]);
                checkEq("t1InstrRvalid", instrBus.rvalid, !seq[k-1]);
                checkEq("t1Rdata", seq[k-1] ? dataBus.rdata : instrBus.rdata, 32'h1000 + k);
            end
            tick();
        end
        instrBus.req = 0; dataBus.req = 0; memBus.rvalid = 1; memBus.rdata = 32'h2000;
        #4;
        checkEq("t1LastInstrRvalid", instrBus.rvalid, 1);
        checkEq("t1LastDataRvalid", dataBus.rvalid, 0);
        tick();

        // Hold: data stalls 3 cycles, fetch arrives in cycle 1 and must wait
        doReset();
        dataBus.req = 1; dataBus.addr = 32'h100; dataBus.we = 1; dataBus.wdata = 32'hDEAD;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin instrBus.req = 1; instrBus.addr = 32'h200; end
            #4;
            checkEq("t2Addr", memBus.addr, 32'h100);
            checkEq("t2MemReq", memBus.req, 1);
            checkEq("t2DataGnt", dataBus.gnt, 0);
            checkEq("t2InstrGnt", instrBus.gnt, 0);
            tick();
        end
        memBus.gnt = 1;
        #4;
        checkEq("t2DataGntC3", dataBus.gnt, 1);
        checkEq("t2InstrGntC3", instrBus.gnt, 0);
        checkEq("t2AddrC3", memBus.addr, 32'h100);
        checkEq("t2WeC3", memBus.we, 1);
        checkEq("t2WdataC3", memBus.wdata, 32'hDEAD);
        tick();
        dataBus.req = 0;
        #4;
        checkEq("t2InstrGntC4", instrBus.gnt, 1);
        checkEq("t2AddrC4", memBus.addr, 32'h200);
        checkEq("t2WeC4", memBus.we, 0);
        tick();
        #4;
        checkEq("t2FullMemReq", memBus.req, 0);
        checkEq("t2FullInstrGnt", instrBus.gnt, 0);

        // Reset with two outstanding, then the next grant is the only entry
        rst_n = 0;
        #2;
        checkEq("t6RstMemReq", memBus.req, 0);
        checkEq("t6RstInstrGnt", instrBus.gnt, 0);
        tick();
        rst_n = 1;
        #4;
        checkEq("t6MemReq", memBus.req, 1);
        checkEq("t6InstrGnt", instrBus.gnt, 1);
        tick();
        instrBus.req = 0; memBus.gnt = 0; memBus.rvalid = 1; memBus.rdata = 32'h55;
        #4;
        checkEq("t6Rvalid", instrBus.rvalid, 1);
        checkEq("t6ErrClear", respErr, 0);
        tick();
        #4;
        checkEq("t6ExtraRvalid", instrBus.rvalid, 0);
        tick();
        memBus.rvalid = 0;
        #4;
        checkEq("t6ErrSet", respErr, 1);

        // Outstanding limit: two fetch grants, then blocked until a response is taken
        doReset();
        instrBus.req = 1; instrBus.addr = 32'h300; memBus.gnt = 1;
        for (int k = 0; k < 2; k++) begin
            #4;
            checkEq("t3Gnt", instrBus.gnt, 1);
            tick();
        end
        #4;
        checkEq("t3Blocked", memBus.req, 0);
        checkEq("t3BlockedGnt", instrBus.gnt, 0);
        tick();
        memBus.rvalid = 1; memBus.rdata = 32'h77;
        #4;
        checkEq("t3RvalidK", instrBus.rvalid, 1);
        checkEq("t3MemReqK", memBus.req, 0);
        tick();
        memBus.rvalid = 0;
        #4;
        checkEq("t3MemReqK1", memBus.req, 1);
        checkEq("t3GntK1", instrBus.gnt, 1);

        // Interleaved I,D,I grants with responses 0xA,0xB,0xC
        doReset();
        memBus.gnt = 1;
        instrBus.req = 1; instrBus.addr = 32'h10;
        #4;
        checkEq("t4InstrGnt0", instrBus.gnt, 1);
        tick();
        instrBus.req = 0; dataBus.req = 1; dataBus.addr = 32'h20;
        memBus.rvalid = 1; memBus.rdata = 32'hA;
        #4;
        checkEq("t4DataGnt1", dataBus.gnt, 1);
        checkEq("t4InstrRvalidA", instrBus.rvalid, 1);
        checkEq("t4DataRvalidA", dataBus.rvalid, 0);
        checkEq("t4InstrRdataA", instrBus.rdata, 32'hA);
        tick();
        dataBus.req = 0; instrBus.req = 1; instrBus.addr = 32'h14; memBus.rdata = 32'hB;
        #4;
        checkEq("t4InstrGnt2", instrBus.gnt, 1);
        checkEq("t4DataRvalidB", dataBus.rvalid, 1);
        checkEq("t4InstrRvalidB", instrBus.rvalid, 0);
        checkEq("t4DataRdataB", dataBus.rdata, 32'hB);
        tick();
        instrBus.req = 0; memBus.rdata = 32'hC;
        #4;
        checkEq("t4InstrRvalidC", instrBus.rvalid, 1);
        checkEq("t4DataRvalidC", dataBus.rvalid, 0);
        checkEq("t4InstrRdataC", instrBus.rdata, 32'hC);
        checkEq("t4NoErr", respErr, 0);
        tick();

        // Spurious response after reset
        doReset();
        memBus.rvalid = 1; memBus.rdata = 32'h99;
        #4;
        checkEq("t5InstrRvalid", instrBus.rvalid, 0);
        checkEq("t5DataRvalid", dataBus.rvalid, 0);
        tick();
        memBus.rvalid = 0;
        #4;
        checkEq("t5ErrSet", respErr, 1);
        tick();
        tick();
        #4;
        checkEq("t5ErrHeld", respErr, 1);
        rst_n = 0;
        #1;
        checkEq("t5ErrCleared", respErr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
